// File: rtl/algo_mrw_refr_sched.sv
// rtl/algo_mrw_refr_sched.sv - tag-SRAM init sweep followed by debt-based refresh scheduling
// Refresh requests accrue as debt; debt is paid when the target bank is idle, or forcibly at the limit.
module algo_mrw_refr_sched #(
  parameter int NUMVROW = 4096,
  parameter int BITVROW = 12,
  parameter int NUMRBNK = 4,
  parameter int BITRBNK = 2,
  parameter int NUMRROW = 256,
  parameter int BITRROW = 8,
  parameter int REFFREQ = 6,
  parameter int REFFRHF = 0,
  parameter int REFMODE = 0,
  parameter int MAXPEND = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refr,
  input  logic [NUMRBNK-1:0] acc_vld,
  output logic               ready,
  output logic               init_write,
  output logic [BITVROW-1:0] init_addr,
  output logic               t1_refrB,
  output logic [BITRBNK-1:0] t1_bankB,
  output logic [BITRROW-1:0] t1_rowB,
  output logic               stall
);

  localparam int TW = $clog2(REFFREQ + 2);
  localparam logic [TW-1:0]      TC_EVEN   = TW'(REFFREQ - 1);
  localparam logic [TW-1:0]      TC_ODD    = TW'(REFFREQ);
  localparam logic [2:0]         MAXD      = 3'(MAXPEND);
  localparam logic [2:0]         STALLD    = 3'(MAXPEND - 1);
  localparam logic [BITVROW-1:0] LAST_ADDR = BITVROW'(NUMVROW - 1);
  localparam logic [BITRBNK-1:0] LAST_BANK = BITRBNK'(NUMRBNK - 1);
  localparam logic [BITRROW-1:0] LAST_ROW  = BITRROW'(NUMRROW - 1);

  typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BITVROW-1:0] r_addr;
  logic [TW-1:0]      r_timer;
  logic               r_odd;
  logic [2:0]         r_debt;
  logic [BITRBNK-1:0] r_bank;
  logic [BITRROW-1:0] r_row;
  logic               r_ready;

  logic               w_run;
  logic [TW-1:0]      w_tc_val;
  logic               w_tc;
  logic               w_req;
  logic               w_req_acc;
  logic               w_issue;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RST:   w_state_nxt = S_INIT;
      S_INIT:  if (r_addr == LAST_ADDR) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_RST;
    endcase
  end

  always_comb begin
    w_run     = (r_state == S_RUN);
    w_tc_val  = (REFFRHF != 0 && r_odd) ? TC_ODD : TC_EVEN;
    w_tc      = (r_timer == w_tc_val);
    w_req     = w_run && ((REFMODE != 0) ? refr : w_tc);
    // A request arriving with the debt already at the limit is lost.
    w_req_acc = w_req && (r_debt < MAXD);
    w_issue   = w_run && (r_debt != 3'd0) && (!acc_vld[r_bank] || (r_debt == MAXD));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RST;
      r_addr  <= '0;
      r_timer <= '0;
      r_odd   <= 1'b0;
      r_debt  <= 3'd0;
      r_bank  <= '0;
      r_row   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      end
      if (w_run) begin
        r_ready <= 1'b1;
        if (REFMODE == 0) begin
          if (w_tc) begin
            r_timer <= '0;
            r_odd   <= ~r_odd;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        case ({w_req_acc, w_issue})
          2'b10:   r_debt <= r_debt + 3'd1;
          2'b01:   r_debt <= r_debt - 3'd1;
          default: r_debt <= r_debt;
        endcase
        if (w_issue) begin
          if (r_bank == LAST_BANK) begin
            r_bank <= '0;
            r_row  <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
          end else begin
            r_bank <= r_bank + 1'b1;
          end
        end
      end
    end
  end

  assign ready      = r_ready;
  assign init_write = (r_state == S_INIT);
  assign init_addr  = init_write ? r_addr : '0;
  assign t1_refrB   = w_issue;
  assign t1_bankB   = w_issue ? r_bank : '0;
  assign t1_rowB    = w_issue ? r_row : '0;
  assign stall      = w_run && (r_debt >= STALLD);

endmodule

// File: tb/tb_algo_mrw_refr_sched.sv
// tb/tb_algo_mrw_refr_sched.sv - three scheduler variants against a cycle-count/debt reference model
// Inputs change after negedge; outputs compared 1ns later; model advances after posedge.
module tb_algo_mrw_refr_sched;

  localparam int NV   = 8;
  localparam int FREQ = 6;
  localparam int ND   = 3;

  localparam int P_FRHF [ND] = '{0, 1, 0};
  localparam int P_MODE [ND] = '{0, 0, 1};
  localparam int P_NB   [ND] = '{4, 4, 3};
  localparam int P_NR   [ND] = '{256, 256, 4};
  localparam int P_MAX  [ND] = '{3, 3, 4};

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       refr_i = 1'b0;
  logic [3:0] acc = 4'd0;

  logic       o_ready [ND];
  logic       o_iw    [ND];
  logic [2:0] o_addr  [ND];
  logic       o_refr  [ND];
  logic [1:0] o_bank  [ND];
  logic [7:0] o_row   [ND];
  logic       o_stall [ND];

  logic [1:0] row2;

  always #5 clk = ~clk;

  algo_mrw_refr_sched #(.NUMVROW(NV), .BITVROW(3), .REFFREQ(FREQ), .REFFRHF(0), .REFMODE(0)) dut0 (
    .clk(clk), .rst(rst_i), .refr(refr_i), .acc_vld(acc),
    .ready(o_ready[0]), .init_write(o_iw[0]), .init_addr(o_addr[0]), .t1_refrB(o_refr[0]),
    .t1_bankB(o_bank[0]), .t1_rowB(o_row[0]), .stall(o_stall[0]));

  algo_mrw_refr_sched #(.NUMVROW(NV), .BITVROW(3), .REFFREQ(FREQ), .REFFRHF(1), .REFMODE(0)) dut1 (
    .clk(clk), .rst(rst_i), .refr(refr_i), .acc_vld(acc),
    .ready(o_ready[1]), .init_write(o_iw[1]), .init_addr(o_addr[1]), .t1_refrB(o_refr[1]),
    .t1_bankB(o_bank[1]), .t1_rowB(o_row[1]), .stall(o_stall[1]));

  algo_mrw_refr_sched #(.NUMVROW(NV), .BITVROW(3), .NUMRBNK(3), .BITRBNK(2), .NUMRROW(4), .BITRROW(2),
                        .REFFREQ(FREQ), .REFFRHF(0), .REFMODE(1), .MAXPEND(4)) dut2 (
    .clk(clk), .rst(rst_i), .refr(refr_i), .acc_vld(acc[2:0]),
    .ready(o_ready[2]), .init_write(o_iw[2]), .init_addr(o_addr[2]), .t1_refrB(o_refr[2]),
    .t1_bankB(o_bank[2]), .t1_rowB(row2), .stall(o_stall[2]));

  assign o_row[2] = {6'd0, row2};

  int n_vec = 0;
  int n_bad = 0;

  int cyc   [ND];
  int trun  [ND];
  int nxt_b [ND];
  int kint  [ND];
  int debt  [ND];
  int bank  [ND];
  int row   [ND];
  bit e_req [ND];
  bit e_iss [ND];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    cyc[k]   = 0;
    trun[k]  = 0;
    nxt_b[k] = FREQ - 1;
    kint[k]  = 0;
    debt[k]  = 0;
    bank[k]  = 0;
    row[k]   = 0;
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic f);
    @(negedge clk);
    rst_i  = r;
    acc    = a;
    refr_i = f;
    #1;
    for (int k = 0; k < ND; k++) begin
      bit run, init, busy;
      run  = cyc[k] > NV;
      init = (cyc[k] >= 1) && (cyc[k] <= NV);
      busy = ((int'(a) >> bank[k]) & 1) != 0;
      e_req[k] = run && ((P_MODE[k] != 0) ? f : (trun[k] == nxt_b[k]));
      e_iss[k] = run && (debt[k] > 0) && (!busy || debt[k] == P_MAX[k]);
      chk($sformatf("d%0d_ready", k), int'(o_ready[k]), int'(cyc[k] > NV + 1));
      chk($sformatf("d%0d_init_write", k), int'(o_iw[k]), int'(init));
      chk($sformatf("d%0d_init_addr", k), int'(o_addr[k]), init ? cyc[k] - 1 : 0);
      chk($sformatf("d%0d_refrB", k), int'(o_refr[k]), int'(e_iss[k]));
      chk($sformatf("d%0d_bankB", k), int'(o_bank[k]), e_iss[k] ? bank[k] : 0);
      chk($sformatf("d%0d_rowB", k), int'(o_row[k]), e_iss[k] ? row[k] : 0);
      chk($sformatf("d%0d_stall", k), int'(o_stall[k]), int'(run && debt[k] >= P_MAX[k] - 1));
    end
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      if (!r) begin
        model_reset(k);
      end else begin
        if (cyc[k] > NV) begin
          debt[k] = debt[k] + ((e_req[k] && debt[k] < P_MAX[k]) ? 1 : 0) - (e_iss[k] ? 1 : 0);
          if (e_iss[k]) begin
            bank[k] = (bank[k] + 1) % P_NB[k];
            if (bank[k] == 0) row[k] = (row[k] + 1) % P_NR[k];
          end
          if (P_MODE[k] == 0 && trun[k] == nxt_b[k]) begin
            kint[k]++;
            nxt_b[k] += FREQ + ((P_FRHF[k] != 0 && (kint[k] % 2) == 1) ? 1 : 0);
          end
          trun[k]++;
        end
        cyc[k]++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < ND; k++) model_reset(k);
    repeat (3) step(1'b0, 4'h0, 1'b0);
    // Init sweep then free-running refresh with idle banks (covers bank wrap and row advance).
    repeat (80) step(1'b1, 4'h0, 1'b0);
    // All banks busy: debt climbs to the limit and issues are forced.
    repeat (30) step(1'b1, 4'hf, 1'b0);
    // Burst of external requests while busy, then release.
    repeat (5) step(1'b1, 4'hf, 1'b1);
    repeat (3) step(1'b1, 4'hf, 1'b0);
    repeat (10) step(1'b1, 4'h0, 1'b0);
    // Reset landing mid-init at row 5, then a full sweep again.
    step(1'b0, 4'h0, 1'b0);
    repeat (6) step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    repeat (20) step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      logic       r;
      logic [3:0] a;
      int         sel;
      r   = ($urandom_range(0, 249) != 0);
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hf : 4'($urandom_range(0, 15));
      step(r, a, $urandom_range(0, 2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/algo_mrw_refr_sched.md
ALGO_MRW_REFR_SCHED -- requirements
Module: algo_mrw_refr_sched

Interface -- parameters (name, default, meaning)
REQ-001 SHALL have NUMVROW, 4096, tag-SRAM rows swept at init.
REQ-002 SHALL have BITVROW, 12, width of init_addr.
REQ-003 SHALL have NUMRBNK, 4, refresh banks (1..16).
REQ-004 SHALL have BITRBNK, 2, width of bank index (min 1).
REQ-005 SHALL have NUMRROW, 256, refresh rows per bank.
REQ-006 SHALL have BITRROW, 8, width of refresh row index.
REQ-007 SHALL have REFFREQ, 6, internal refresh interval in cycles (>=2).
REQ-008 SHALL have REFFRHF, 0, 1 = intervals alternate REFFREQ and REFFREQ+1.
REQ-009 SHALL have REFMODE, 0, 0 = internal timer, 1 = external refr pulses.
REQ-010 SHALL have MAXPEND, 3, refresh debt limit (1..7).

Interface -- ports (name direction width meaning)
REQ-011 SHALL have clk input 1, single clock; all logic on rising edge.
REQ-012 SHALL have rst input 1, synchronous active-low reset.
REQ-013 SHALL have refr input 1, external refresh request pulse (REFMODE=1 only).
REQ-014 SHALL have acc_vld input NUMRBNK, per-bank core access this cycle.
REQ-015 SHALL have ready output 1, init complete.
REQ-016 SHALL have init_write output 1, tag-SRAM init write strobe.
REQ-017 SHALL have init_addr output BITVROW, tag-SRAM init row.
REQ-018 SHALL have t1_refrB output 1, refresh issue strobe.
REQ-019 SHALL have t1_bankB output BITRBNK, bank refreshed.
REQ-020 SHALL have t1_rowB output BITRROW, row refreshed.
REQ-021 SHALL have stall output 1, core must idle next cycle (debt at limit).

Function
REQ-022 SHALL implement states RST, INIT, RUN; RST entered while rst=0.
REQ-023 SHALL move RST->INIT on first cycle with rst=1.
REQ-024 SHALL in INIT assert init_write=1, init_addr=0..NUMVROW-1, one row per cycle.
REQ-025 SHALL move INIT->RUN after row NUMVROW-1; ready=1 from next cycle, sticky until reset.
REQ-026 SHALL hold timer, debt, bank and row counters at 0 in RST and INIT.
REQ-027 SHALL in RUN, REFMODE=0, count timer 0..REFFREQ-1 (or REFFREQ when REFFRHF=1, odd interval); terminal count = one request.
REQ-028 SHALL in RUN, REFMODE=1, treat each cycle refr=1 as one request; timer unused.
REQ-029 SHALL keep debt counter (3 bits): +1 per request, -1 per issue, both same cycle = unchanged.
REQ-030 SHALL saturate debt at MAXPEND; a request at MAXPEND is dropped.
REQ-031 SHALL issue (t1_refrB=1) when debt>0 and acc_vld[bank]=0, or when debt=MAXPEND regardless of acc_vld.
REQ-032 SHALL assert stall=1 whenever debt>=MAXPEND-1 in RUN, else 0.
REQ-033 SHALL drive t1_bankB/t1_rowB combinationally from current bank/row counters during issue, 0 otherwise.
REQ-034 SHALL on issue advance bank modulo NUMRBNK; on bank wrap advance row modulo NUMRROW.
REQ-035 SHALL have zero latency from eligibility to t1_refrB (same cycle), counters update next edge.
REQ-036 SHALL never assert t1_refrB outside RUN nor init_write outside INIT.

Reset
REQ-037 SHALL on rst=0 at any edge, including mid-INIT or mid-refresh, return to RST next cycle with ready=0, init_write=0, init_addr=0, t1_refrB=0, t1_bankB=0, t1_rowB=0, stall=0, all counters 0.
REQ-038 SHALL restart the full init sweep after every reset; no partial resume.

Verification
REQ-039 SHALL test: NUMVROW=8, release rst -> init_write 8 cycles addr 0..7, ready=1 on cycle 10 after release.
REQ-040 SHALL test: REFMODE=0, REFFREQ=6, acc_vld=0 -> t1_refrB every 6 cycles, banks 0,1,2,3,0, t1_rowB increments to 1 at fifth issue.
REQ-041 SHALL test: REFFRHF=1, REFFREQ=6 -> issue spacing alternates 6,7,6,7.
REQ-042 SHALL test: acc_vld=all-ones held, MAXPEND=3 -> no issue until debt=3, stall=1 from debt=2, forced issue at debt=3.
REQ-043 SHALL test: REFMODE=1, refr pulsed 5 cycles in a row with acc_vld=all-ones -> debt saturates at 3, extra requests dropped, exactly 3 issues after acc_vld released.
REQ-044 SHALL test: rst=0 asserted mid-INIT at addr 5 -> all outputs 0 next cycle, sweep restarts at 0 after release.
